shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Multi-cycle controller that sequences the ALU's fixed-distance shift stages (1, 2, 4, 8, 16) to perform a variable shift. It applies one power-of-two stage per clock and skips stages whose shamt bit is zero, so latency depends on the shift amount. It sits beside the ALU and serves the execute stage through a start/ready/done handshake, so one small shift datapath can replace a full barrel shifter.

Parameters:
WIDTH, 32, data width; must equal 2**SHAMT_W
SHAMT_W, 5, shift-amount width; one stage per bit

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when ready=1
op  input  2  00 SLL, 01 SRA, 10 SRL, 11 ROR (rotate right)
data_in  input  WIDTH  operand, sampled on accepted start
shamt  input  SHAMT_W  shift amount, sampled on accepted start
ready  output  1  high in IDLE and DONE
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse in DONE
result  output  WIDTH  shifted value; valid while done=1; held until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE and clears every register.
  - Outputs during and after reset: ready=1, busy=0, done=0, result=0.
  - Reset mid-operation abandons the shift; no done pulse is produced.
- Internal registers: acc (WIDTH), rem (SHAMT_W, remaining shift bits), op_r (2).
- States:
  - IDLE: when start=1, load acc<=data_in, rem<=shamt, op_r<=op.
    - If shamt==0, go to DONE.
    - Otherwise go to SHIFT.
  - SHIFT: each cycle, select k = index of the highest set bit of rem.
    - Apply a 2**k shift to acc per op_r, then clear rem[k].
    - When the updated rem==0, go to DONE; otherwise stay in SHIFT.
    - start is ignored while in SHIFT.
  - DONE: done=1 and result=acc for exactly one cycle.
    - If start=1 in DONE, load new operands as in IDLE (back-to-back issue; no idle bubble). Otherwise go to IDLE.
- Stage arithmetic, for a 2**k shift:
  - SLL: zero-fill on the low side.
  - SRA: replicate acc[WIDTH-1] into the top 2**k bits.
  - SRL: zero-fill on the high side.
  - ROR: acc rotated right by 2**k.
- Because sign fill is taken from acc, sign fill remains correct across stages.
- Latency: with start accepted at edge T0, done is high in the cycle after edge T0+popcount(shamt).
  - shamt=0: done in the cycle immediately after acceptance.
  - shamt=31: five SHIFT cycles, then DONE.
- result is a register.
  - It updates only when entering DONE.
  - It is stable between done pulses; SHIFT cycles never alter it.
- No dependence between operations: a new start in DONE does not disturb the result presented that cycle.

Test Plan:
- Reset: assert reset=0 mid-SHIFT (op SRA, shamt 31) -> immediately ready=1, busy=0, result=0; no done pulse follows the release of reset.
- SRA sign: data_in=32'h8000_0010, shamt=2, op=01 -> one SHIFT cycle, then done with result=32'hE000_0004. Same with shamt=31 -> 5 SHIFT cycles, result=32'hFFFF_FFFF.
- SLL/SRL: data_in=32'h0000_00F1, shamt=5, op SLL -> 2 SHIFT cycles, result=32'h0000_1E20. data_in=32'hF000_0000, shamt=4, op SRL -> 1 SHIFT cycle, result=32'h0F00_0000.
- ROR and zero shift: data_in=32'h1234_5678, shamt=8, op ROR -> result=32'h7812_3456. shamt=0 -> done in the next cycle with result=32'h1234_5678 and busy never high.
- Handshake: pulse start during SHIFT with different operands -> those operands are ignored and the result belongs to the first operation. Hold start high through DONE -> the second operation starts with no IDLE cycle, and the first result is still visible for its done cycle.
- Random: 1000 random op/data/shamt combinations checked against a reference model; done latency equals popcount(shamt)+1 cycles.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle variable shifter built from fixed power-of-two
// stages (1, 2, 4, ... 2**(SHAMT_W-1)). Each clock applies the largest
// remaining stage selected by the shift amount. Stages whose amount bit is
// zero are skipped, so latency is popcount(shamt) SHIFT cycles plus one
// DONE cycle.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset
//   start   - request, accepted only while ready=1
//   op      - 00 SLL, 01 SRA, 10 SRL, 11 ROR
//   data_in - operand, sampled on an accepted start
//   shamt   - shift amount, sampled on an accepted start
//   ready   - high in IDLE and DONE
//   busy    - high in SHIFT
//   done    - one-cycle pulse per completed operation
//   result  - registered result; changes only when entering DONE
//
// WIDTH must equal 2**SHAMT_W. The rotate stage relies on this: its
// left-shift distance is computed modulo WIDTH in SHAMT_W bits.
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SLL = 2'b00, SRA = 2'b01, SRL = 2'b10, ROR = 2'b11} op_t;

    state_t             state;
    op_t                op_r;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;

    // top is the highest set bit of rem as a one-hot value; numerically
    // that is exactly the stage distance 2**k.
    logic [SHAMT_W-1:0] top;
    logic [SHAMT_W-1:0] rem_nxt;
    logic [SHAMT_W-1:0] lsh;
    logic [WIDTH-1:0]   acc_nxt;

    always_comb begin
        top = '0;
        for (int i = 0; i < SHAMT_W; i++)
            if (rem[i]) top = SHAMT_W'(1) << i;
        rem_nxt = rem & ~top;
        // Rotate right by d == rotate left by WIDTH-d; -top wraps modulo WIDTH.
        // top is never zero while in SHIFT, so no full-width shift occurs.
        lsh = SHAMT_W'(0) - top;
        case (op_r)
            SLL:     acc_nxt = acc << top;
            SRA:     acc_nxt = $signed(acc) >>> top;
            SRL:     acc_nxt = acc >> top;
            default: acc_nxt = (acc >> top) | (acc << lsh);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_r   <= SLL;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // Accepting in DONE gives back-to-back issue; result of
                    // the finishing op is still on the port this cycle.
                    if (start) begin
                        acc  <= data_in;
                        rem  <= shamt;
                        op_r <= op_t'(op);
                        if (shamt == '0) begin
                            state  <= DONE;
                            result <= data_in;
                            done   <= 1'b1;
                            ready  <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            state <= SHIFT;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    rem <= rem_nxt;
                    if (rem_nxt == '0) begin
                        state  <= DONE;
                        result <= acc_nxt;
                        done   <= 1'b1;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
